// File: rtl/sync_fifo_param_if.sv
// Bus interface for sync_fifo_param: producer/consumer handshake, data and status.
// master = the side driving requests (producer/consumer logic or a testbench),
// slave  = the FIFO itself.
interface sync_fifo_param_if #(
  parameter int DW = 9,
  parameter int LW = 5
);
  logic          clr;
  logic [DW-1:0] datain;
  logic          we;
  logic          re;
  logic          readyin;
  logic [DW-1:0] dataout;
  logic          readyout;
  logic [LW-1:0] level;
  logic          almost_full;
  logic          almost_empty;
  logic          error;

  modport master (
    output clr, datain, we, re,
    input  readyin, dataout, readyout, level, almost_full, almost_empty, error
  );

  modport slave (
    input  clr, datain, we, re,
    output readyin, dataout, readyout, level, almost_full, almost_empty, error
  );
endinterface

// File: rtl/sync_fifo_param.sv
// Parametrised single-clock FIFO with synchronous clear, occupancy level,
// almost-full/almost-empty flags and a one-cycle overflow/underflow error pulse.
// Optional macro SYNC_FIFO_FWFT_EN selects first-word-fall-through output;
// when undefined, reads are registered with one cycle of latency.
// The interface instance must be built with LW = $clog2(DEPTH)+1.
module sync_fifo_param #(
  parameter int DW        = 9,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input logic               clk0,
  input logic               rstn,
  sync_fifo_param_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [DW-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [LW-1:0] r_level;
  logic          r_error;
  logic [DW-1:0] r_dout;

  logic w_readyin;
  logic w_readyout;
  logic w_wr_acc;
  logic w_rd_acc;

  // Status flags come only from the registered level, never from we/re.
  assign w_readyin  = (r_level != LW'(DEPTH));
  assign w_readyout = (r_level != '0);
  assign w_wr_acc   = bus.we & w_readyin  & ~bus.clr;
  assign w_rd_acc   = bus.re & w_readyout & ~bus.clr;

  assign bus.readyin      = w_readyin;
  assign bus.readyout     = w_readyout;
  assign bus.level        = r_level;
  assign bus.almost_full  = (r_level >= LW'(AF_THRESH));
  assign bus.almost_empty = (r_level <= LW'(AE_THRESH));
  assign bus.error        = r_error;

  // Pointer, level and error bookkeeping; clr overrides any request.
  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_error  <= 1'b0;
    end else if (bus.clr) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_error  <= 1'b0;
    end else begin
      r_error <= (bus.we & ~w_readyin) | (bus.re & ~w_readyout);
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr_acc && !w_rd_acc)      r_level <= r_level + LW'(1);
      else if (w_rd_acc && !w_wr_acc) r_level <= r_level - LW'(1);
    end
  end

  // Storage array; contents are deliberately left unreset.
  always_ff @(posedge clk0) begin
    if (w_wr_acc) r_mem[r_wr_ptr] <= bus.datain;
  end

  // Output register: holds the most recently popped word.
  always_ff @(posedge clk0 or negedge rstn) begin
    if (!rstn)         r_dout <= '0;
    else if (w_rd_acc) r_dout <= r_mem[r_rd_ptr];
  end

`ifdef SYNC_FIFO_FWFT_EN
  // Head of queue is visible directly; when empty, show the last popped word.
  assign bus.dataout = w_readyout ? r_mem[r_rd_ptr] : r_dout;
`else
  // Registered read: data appears the cycle after the accepted read.
  assign bus.dataout = r_dout;
`endif

endmodule
